// File: rtl/iodelay_tap_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// iodelay_pkg
// Shared types for the IODELAY tap sequencer:
//   - iodelay_tap_state_e : sequencer FSM states
//   - iodelay_tap_done_s  : completion record {lane, tap, mismatch, abort}
// The done record is sized from the package default geometry
// (iodelay_lanes_c lanes, iodelay_tap_width_c-bit taps). The sequencer's
// parameters default to the same values.
// ---------------------------------------------------------------------------
package iodelay_pkg;

    localparam int unsigned iodelay_lanes_c      = 4;
    localparam int unsigned iodelay_tap_width_c  = 5;
    localparam int unsigned iodelay_lane_width_c = $clog2(iodelay_lanes_c);

    typedef enum logic [2:0] {
        eWaitRdy = 3'd0,
        eIdle    = 3'd1,
        eLoad    = 3'd2,
        eSettle  = 3'd3,
        eCheck   = 3'd4
    } iodelay_tap_state_e;

    typedef struct packed {
        logic [iodelay_lane_width_c-1:0] lane;
        logic [iodelay_tap_width_c-1:0]  tap;
        logic                            mismatch;
        logic                            abort;
    } iodelay_tap_done_s;

endpackage

// File: rtl/iodelay_tap_sequencer_arb.sv
// ---------------------------------------------------------------------------
// bsg_arb_round_robin
// Round-robin arbiter. Grants the first requester at or after the pointer
// (wrapping). The pointer advances to (granted lane + 1) mod width_p only
// when the grant is consumed (yumi), so an unconsumed grant leaves the
// priority order untouched.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   reqs       : request vector
//   yumi       : the current grant is taken this cycle
//   grants     : one-hot grant (combinational)
//   valid      : some request is granted
//   tag        : index of the granted requester
// ---------------------------------------------------------------------------
module bsg_arb_round_robin #(
    parameter int unsigned width_p = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [width_p-1:0]   reqs,
    input  logic                 yumi,
    output logic [width_p-1:0]   grants,
    output logic                 valid,
    output logic [((width_p > 1) ? $clog2(width_p) : 1)-1:0] tag
);

    localparam int unsigned lg_lp = (width_p > 1) ? $clog2(width_p) : 1;
    localparam logic [width_p-1:0] one_hot0_lp = {{(width_p-1){1'b0}}, 1'b1};
    localparam logic [lg_lp-1:0]   last_lp     = lg_lp'(width_p - 1);

    logic [lg_lp-1:0] ptr_r;
    logic [lg_lp-1:0] tag_s;
    logic             found_s;

    // Priority search starting at the pointer, wrapping past the top lane.
    always_comb begin
        found_s = 1'b0;
        tag_s   = {lg_lp{1'b0}};
        for (int i = 0; i < int'(width_p); i++) begin
            int idx;
            idx = int'(ptr_r) + i;
            if (idx >= int'(width_p)) begin
                idx = idx - int'(width_p);
            end else begin
                idx = idx;
            end
            if (!found_s && reqs[idx]) begin
                found_s = 1'b1;
                tag_s   = lg_lp'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign valid  = found_s;
    assign tag    = tag_s;
    assign grants = found_s ? (one_hot0_lp << tag_s) : {width_p{1'b0}};

    // Pointer moves past the consumed grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {lg_lp{1'b0}};
        end else if (yumi && found_s) begin
            ptr_r <= (tag_s == last_lp) ? {lg_lp{1'b0}} : (tag_s + lg_lp'(1));
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/iodelay_tap_sequencer.sv
// ---------------------------------------------------------------------------
// iodelay_tap_sequencer
// Loads tap values into a bank of IDELAYE2 (VAR_LOAD) elements through one
// shared CNTVALUEIN bus. Requesters are served round-robin, only while the
// synchronized IDELAYCTRL RDY is high; each LD pulse is followed by a
// settle window and a one-cycle check/completion step.
//
// Configuration macro: IODELAY_TAP_READBACK_EN
//   defined   : done_mismatch_o compares CNTVALUEOUT of the loaded lane
//               against the loaded tap in the check cycle.
//   undefined : cntvalueout_i is ignored, done_mismatch_o is 0. Latency is
//               identical in both builds.
//
// Ports:
//   clk_i, reset_n_i   : IODELAY reference clock, async active-low reset
//   ctrl_rdy_i         : IDELAYCTRL RDY (asynchronous, 2-flop synchronized)
//   req_v_i/req_tap_i  : per-lane request valid and tap (lane k = slice k)
//   req_ready_o        : per-lane accept (combinational, at most one high)
//   ld_o, cntvaluein_o : IDELAYE2 LD strobes and shared CNTVALUEIN
//   cntvalueout_i      : per-lane CNTVALUEOUT readback
//   busy_o             : high whenever the sequencer is not idle
//   done_*_o           : one-cycle completion/abort report
// ---------------------------------------------------------------------------
module iodelay_tap_sequencer
    import iodelay_pkg::*;
#(
    parameter int unsigned lanes_p         = iodelay_lanes_c,
    parameter int unsigned tap_width_p     = iodelay_tap_width_c,
    parameter int unsigned settle_cycles_p = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           ctrl_rdy_i,
    input  logic [lanes_p-1:0]             req_v_i,
    input  logic [lanes_p*tap_width_p-1:0] req_tap_i,
    output logic [lanes_p-1:0]             req_ready_o,
    output logic [lanes_p-1:0]             ld_o,
    output logic [tap_width_p-1:0]         cntvaluein_o,
    input  logic [lanes_p*tap_width_p-1:0] cntvalueout_i,
    output logic                           busy_o,
    output logic                           done_v_o,
    output logic [$clog2(lanes_p)-1:0]     done_lane_o,
    output logic [tap_width_p-1:0]         done_tap_o,
    output logic                           done_mismatch_o,
    output logic                           done_abort_o
);

    localparam int unsigned lane_w_lp = $clog2(lanes_p);
    localparam int unsigned cnt_w_lp  = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;
    localparam logic [cnt_w_lp-1:0] settle_init_lp = cnt_w_lp'(settle_cycles_p - 1);
    localparam logic [lanes_p-1:0]  one_hot0_lp    = {{(lanes_p-1){1'b0}}, 1'b1};

    iodelay_tap_state_e state_r, state_s;

    logic                   rdy_meta_r;
    logic                   rdy_sync_r;
    logic [cnt_w_lp-1:0]    cnt_r, cnt_s;
    logic [lane_w_lp-1:0]   lane_r, lane_s;
    logic [tap_width_p-1:0] tap_r, tap_s;
    logic                   busy_r;

    logic                   accept_s;
    logic                   abort_s;
    logic                   complete_s;
    logic                   mismatch_raw_s;
    logic [lanes_p-1:0]     arb_grants_s;
    logic                   arb_v_s;
    logic [lane_w_lp-1:0]   arb_tag_s;
    iodelay_tap_done_s      done_s;

    bsg_arb_round_robin #(
        .width_p (lanes_p)
    ) u_arb (
        .clk    (clk_i),
        .rst_n  (reset_n_i),
        .reqs   (req_v_i),
        .yumi   (accept_s),
        .grants (arb_grants_s),
        .valid  (arb_v_s),
        .tag    (arb_tag_s)
    );

`ifdef IODELAY_TAP_READBACK_EN
    logic [tap_width_p-1:0] readback_s;
    assign readback_s     = cntvalueout_i[lane_r*tap_width_p +: tap_width_p];
    assign mismatch_raw_s = (readback_s != tap_r);
`else
    logic unused_readback_s;
    assign unused_readback_s = ^cntvalueout_i;
    assign mismatch_raw_s    = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous IDELAYCTRL RDY.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdy_meta_r <= 1'b0;
            rdy_sync_r <= 1'b0;
        end else begin
            rdy_meta_r <= ctrl_rdy_i;
            rdy_sync_r <= rdy_meta_r;
        end
    end

    // FSM state, settle counter, latched request and busy flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= eWaitRdy;
            cnt_r   <= {cnt_w_lp{1'b0}};
            lane_r  <= {lane_w_lp{1'b0}};
            tap_r   <= {tap_width_p{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            lane_r  <= lane_s;
            tap_r   <= tap_s;
            busy_r  <= (state_s != eIdle);
        end
    end

    // Next-state logic; a RDY drop during an operation aborts it.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        lane_s     = lane_r;
        tap_s      = tap_r;
        accept_s   = 1'b0;
        abort_s    = 1'b0;
        complete_s = 1'b0;
        case (state_r)
            eWaitRdy: begin
                if (rdy_sync_r) begin
                    state_s = eIdle;
                end else begin
                    state_s = eWaitRdy;
                end
            end
            eIdle: begin
                if (!rdy_sync_r) begin
                    state_s = eWaitRdy;
                end else if (arb_v_s) begin
                    accept_s = 1'b1;
                    lane_s   = arb_tag_s;
                    tap_s    = req_tap_i[arb_tag_s*tap_width_p +: tap_width_p];
                    state_s  = eLoad;
                end else begin
                    state_s = eIdle;
                end
            end
            eLoad: begin
                if (!rdy_sync_r) begin
                    abort_s = 1'b1;
                    cnt_s   = {cnt_w_lp{1'b0}};
                    state_s = eWaitRdy;
                end else begin
                    cnt_s   = settle_init_lp;
                    state_s = eSettle;
                end
            end
            eSettle: begin
                if (!rdy_sync_r) begin
                    abort_s = 1'b1;
                    cnt_s   = {cnt_w_lp{1'b0}};
                    state_s = eWaitRdy;
                end else if (cnt_r == {cnt_w_lp{1'b0}}) begin
                    state_s = eCheck;
                end else begin
                    cnt_s   = cnt_r - cnt_w_lp'(1);
                    state_s = eSettle;
                end
            end
            eCheck: begin
                if (!rdy_sync_r) begin
                    abort_s = 1'b1;
                    state_s = eWaitRdy;
                end else begin
                    complete_s = 1'b1;
                    state_s    = eIdle;
                end
            end
            default: begin
                state_s = eWaitRdy;
            end
        endcase
    end

    // Output decode from registered state; ld is suppressed in a RDY-drop cycle.
    always_comb begin
        if (accept_s) begin
            req_ready_o = arb_grants_s;
        end else begin
            req_ready_o = {lanes_p{1'b0}};
        end

        if ((state_r == eLoad) && rdy_sync_r) begin
            ld_o = one_hot0_lp << lane_r;
        end else begin
            ld_o = {lanes_p{1'b0}};
        end

        if (state_r == eWaitRdy) begin
            cntvaluein_o = {tap_width_p{1'b0}};
        end else begin
            cntvaluein_o = tap_r;
        end

        if (abort_s || complete_s) begin
            done_s.lane     = lane_r;
            done_s.tap      = tap_r;
            done_s.mismatch = complete_s & mismatch_raw_s;
            done_s.abort    = abort_s;
        end else begin
            done_s = '{default: 1'b0};
        end
    end

    assign busy_o          = busy_r;
    assign done_v_o        = abort_s | complete_s;
    assign done_lane_o     = done_s.lane;
    assign done_tap_o      = done_s.tap;
    assign done_mismatch_o = done_s.mismatch;
    assign done_abort_o    = done_s.abort;

endmodule

// File: tb/tb_iodelay_tap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_iodelay_tap_sequencer
// Directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model: each load is tracked by its age in cycles since
// the accept (LD at age 1, done at age 2+settle), RDY is a two-stage delay
// line, and arbitration is a plain modulo search from a pointer.
// ---------------------------------------------------------------------------
module tb_iodelay_tap_sequencer;

    localparam int L = 4;
    localparam int W = 5;
    localparam int S = 8;
`ifdef IODELAY_TAP_READBACK_EN
    localparam bit rb_on = 1'b1;
`else
    localparam bit rb_on = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n_i;
    logic             ctrl_rdy_i;
    logic [L-1:0]     req_v_i;
    logic [L*W-1:0]   req_tap_i;
    logic [L-1:0]     req_ready_o;
    logic [L-1:0]     ld_o;
    logic [W-1:0]     cntvaluein_o;
    logic [L*W-1:0]   cntvalueout_i;
    logic             busy_o;
    logic             done_v_o;
    logic [1:0]       done_lane_o;
    logic [W-1:0]     done_tap_o;
    logic             done_mismatch_o;
    logic             done_abort_o;

    always #5 clk = ~clk;

    iodelay_tap_sequencer #(
        .lanes_p(L), .tap_width_p(W), .settle_cycles_p(S)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .ctrl_rdy_i(ctrl_rdy_i),
        .req_v_i(req_v_i), .req_tap_i(req_tap_i), .req_ready_o(req_ready_o),
        .ld_o(ld_o), .cntvaluein_o(cntvaluein_o), .cntvalueout_i(cntvalueout_i),
        .busy_o(busy_o), .done_v_o(done_v_o), .done_lane_o(done_lane_o),
        .done_tap_o(done_tap_o), .done_mismatch_o(done_mismatch_o),
        .done_abort_o(done_abort_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    bit m_sync1, m_sync2, m_wait, m_active, m_busy;
    int m_age, m_lane, m_tap, m_ptr, m_last_tap;

    // Observations for directed scenarios
    logic [L-1:0] last_ready;
    bit last_done, last_abort, last_mis;
    int last_lane, last_tap, last_accept_cycle;
    int cyc_count = 0;

    function automatic int lane_val(input logic [L*W-1:0] v, input int k);
        logic [L*W-1:0] t;
        t = v >> (k*W);
        return int'(t[W-1:0]);
    endfunction

    task automatic model_reset();
        m_sync1 = 0; m_sync2 = 0; m_wait = 1; m_active = 0; m_busy = 0;
        m_age = 0; m_lane = 0; m_tap = 0; m_ptr = 0; m_last_tap = 0;
    endtask

    // Called at a falling edge after inputs are driven: compare, then advance
    // the model over the coming rising edge.
    task automatic eval_cycle();
        logic [L-1:0] e_ready, e_ld;
        bit e_done, e_abort, e_mis, n_wait, n_active;
        int e_cval, g, n_age;
        #1;
        e_ready = '0; e_ld = '0; e_done = 0; e_abort = 0; e_mis = 0; g = -1;
        n_wait = m_wait; n_active = m_active; n_age = m_age;
        e_cval = m_wait ? 0 : m_last_tap;
        if (m_wait) begin
            if (m_sync2) n_wait = 0;
        end else if (!m_active) begin
            if (!m_sync2) begin
                n_wait = 1;
            end else begin
                for (int i = 0; i < L; i++) begin
                    int k;
                    k = (m_ptr + i) % L;
                    if (g < 0 && req_v_i[k]) g = k;
                end
                if (g >= 0) begin
                    e_ready[g] = 1'b1; n_active = 1; n_age = 1;
                end
            end
        end else begin
            if (!m_sync2) begin
                e_done = 1; e_abort = 1; n_active = 0; n_wait = 1;
            end else begin
                if (m_age == 1) e_ld[m_lane] = 1'b1;
                if (m_age == 2 + S) begin
                    e_done = 1;
                    e_mis = rb_on && (lane_val(cntvalueout_i, m_lane) != m_tap);
                    n_active = 0;
                end else begin
                    n_age = m_age + 1;
                end
            end
        end

        check_val("req_ready", req_ready_o, e_ready);
        check_val("ld", ld_o, e_ld);
        check_val("cntvaluein", cntvaluein_o, e_cval);
        check_val("busy", busy_o, m_busy);
        check_val("done_v", done_v_o, e_done);
        if (e_done) begin
            check_val("done_lane", done_lane_o, m_lane);
            check_val("done_tap", done_tap_o, m_tap);
            check_val("done_mismatch", done_mismatch_o, e_mis);
            check_val("done_abort", done_abort_o, e_abort);
        end

        last_ready = req_ready_o;
        last_done  = done_v_o;
        last_abort = done_abort_o;
        last_mis   = done_mismatch_o;
        last_lane  = int'(done_lane_o);
        last_tap   = int'(done_tap_o);
        if (req_ready_o != '0) last_accept_cycle = cyc_count;

        if (g >= 0) begin
            m_lane = g; m_tap = lane_val(req_tap_i, g); m_last_tap = m_tap;
            m_ptr = (g + 1) % L;
        end
        m_wait = n_wait; m_active = n_active; m_age = n_age;
        m_busy = n_wait || n_active;
        m_sync2 = m_sync1; m_sync1 = ctrl_rdy_i;
        cyc_count++;
    endtask

    task automatic cyc();
        eval_cycle();
        @(negedge clk);
    endtask

    // Cycles from now until an accept is seen (0 = this cycle), -1 on timeout.
    task automatic wait_accept(input int budget, output int cycles);
        cycles = -1;
        for (int k = 0; k < budget; k++) begin
            eval_cycle();
            if (last_ready != '0) begin
                cycles = k;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    // Cycles since the accept until a done pulse, -1 on timeout.
    task automatic wait_done(input int budget, output int cycles);
        cycles = -1;
        for (int k = 1; k <= budget; k++) begin
            eval_cycle();
            if (last_done) begin
                cycles = k;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    int lat, dl;
    int acc_cycles[5];
    int acc_lanes[5];

    initial begin
        reset_n_i = 1'b0; ctrl_rdy_i = 1'b0; req_v_i = '0;
        req_tap_i = '0; cntvalueout_i = '0;
        last_ready = '0; last_done = 0; last_abort = 0; last_mis = 0;
        last_lane = 0; last_tap = 0; last_accept_cycle = -1;
        model_reset();
        #2;
        check_val("reset_ld", ld_o, 0);
        check_val("reset_busy", busy_o, 0);
        check_val("reset_done_v", done_v_o, 0);
        check_val("reset_cntvaluein", cntvaluein_o, 0);
        @(negedge clk);
        reset_n_i = 1'b1;

        // RDY gating: requests are held off while RDY is low
        req_v_i = 4'b0001;
        req_tap_i = (L*W)'($urandom);
        for (int i = 0; i < 6; i++) cyc();
        ctrl_rdy_i = 1'b1;
        wait_accept(10, lat);
        check_val("rdy_latency", lat, 3);
        req_v_i = '0;

        // Single load: lane 2, tap 17
        cntvalueout_i = '0; cntvalueout_i[2*W +: W] = 5'd17;
        req_tap_i = '0; req_tap_i[2*W +: W] = 5'd17;
        wait_done(20, dl);
        for (int i = 0; i < 2; i++) cyc();
        req_v_i = 4'b0100;
        wait_accept(5, lat);
        check_val("single_accept", lat, 0);
        req_v_i = '0;
        wait_done(20, dl);
        check_val("single_done_latency", dl, 2 + S);
        check_val("single_lane", last_lane, 2);
        check_val("single_tap", last_tap, 17);
        check_val("single_mismatch", last_mis, 0);

        // Readback mismatch: lane 1 loaded with 9, readback 3
        cntvalueout_i = '0; cntvalueout_i[1*W +: W] = 5'd3;
        req_tap_i = '0; req_tap_i[1*W +: W] = 5'd9;
        req_v_i = 4'b0010;
        wait_accept(5, lat);
        req_v_i = '0;
        wait_done(20, dl);
        check_val("readback_tap", last_tap, 9);
        check_val("readback_mismatch", last_mis, rb_on);

        // Abort: RDY drops during the settle window
        req_tap_i = '0; req_tap_i[0 +: W] = 5'd6;
        req_v_i = 4'b0001;
        wait_accept(5, lat);
        req_v_i = '0;
        for (int i = 0; i < 3; i++) cyc();
        ctrl_rdy_i = 1'b0;
        wait_done(20, dl);
        check_val("abort_flag", last_abort, 1);
        check_val("abort_lane", last_lane, 0);
        req_v_i = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            eval_cycle();
            check_val("abort_busy_hold", busy_o, 1);
            @(negedge clk);
        end
        ctrl_rdy_i = 1'b1;
        wait_accept(10, lat);
        check_val("abort_recover_latency", lat, 3);

        // Async reset in the LD cycle
        req_v_i = '0;
        eval_cycle();
        #2;
        reset_n_i = 1'b0;
        #1;
        check_val("areset_ld", ld_o, 0);
        check_val("areset_busy", busy_o, 0);
        check_val("areset_done_v", done_v_o, 0);
        model_reset();
        @(negedge clk);
        reset_n_i = 1'b1;

        // Round-robin with all lanes requesting
        req_v_i = 4'b1111;
        req_tap_i = (L*W)'($urandom);
        for (int n = 0; n < 5; n++) begin
            wait_accept(20, lat);
            acc_cycles[n] = last_accept_cycle;
            acc_lanes[n]  = $clog2(int'(last_ready));
        end
        for (int n = 0; n < 5; n++) begin
            check_val("rr_lane", acc_lanes[n], n % L);
            if (n > 0) check_val("rr_spacing", acc_cycles[n] - acc_cycles[n-1], 3 + S);
        end

        // Randomized traffic with occasional RDY drops
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) ctrl_rdy_i = ~ctrl_rdy_i;
            if ($urandom_range(0, 199) == 0) ctrl_rdy_i = 1'b1;
            req_v_i   = L'($urandom);
            req_tap_i = (L*W)'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < L; k++) cntvalueout_i[k*W +: W] = W'(m_tap);
            end else begin
                cntvalueout_i = (L*W)'($urandom);
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
